// File: rtl/mem_stage.sv
// MEM stage: runs loads/stores over a req/ack handshake,
// stalls upstream while busy, registers the MEM->WB bundle.
module mem_stage #(
  parameter int MEM_BASE = 1024,
  parameter int TIMEOUT  = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        WB_EN_IN,
  input  logic        MEM_R_EN_IN,
  input  logic        MEM_W_EN_IN,
  input  logic [31:0] PCIn,
  input  logic [31:0] ALUResIn,
  input  logic [31:0] STValIn,
  input  logic [4:0]  destIn,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  output logic        freeze,
  output logic        WB_EN,
  output logic        MEM_R_EN,
  output logic [31:0] PC,
  output logic [31:0] ALURes,
  output logic [31:0] MemData,
  output logic [4:0]  dest,
  output logic        mem_err
);

  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] CNT_LAST =
    CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  typedef enum logic {
    S_IDLE,
    S_BUSY
  } state_t;

  state_t        r_state;
  state_t        w_next;
  logic [CW-1:0] r_cnt;
  logic          w_memop;
  logic          w_tmo;
  logic          w_issue;
  logic          w_done;
  logic          w_abort;
  logic          w_pass;
  logic [31:0]   w_addr;

  assign w_memop = MEM_R_EN_IN | MEM_W_EN_IN;
  assign w_tmo   = (TIMEOUT != 0) && (r_cnt == CNT_LAST);
  assign w_addr  = (ALUResIn - 32'(MEM_BASE)) & 32'hFFFF_FFFC;

  // Next state, stall and per-cycle action strobes
  always_comb begin
    w_next  = r_state;
    w_issue = 1'b0;
    w_done  = 1'b0;
    w_abort = 1'b0;
    freeze  = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (w_memop) begin
          freeze  = 1'b1;
          w_issue = 1'b1;
          w_next  = S_BUSY;
        end
      end
      S_BUSY: begin
        if (mem_ack) begin
          w_done = 1'b1;
          w_next = S_IDLE;
        end else if (w_tmo) begin
          w_abort = 1'b1;
          w_next  = S_IDLE;
        end else begin
          freeze = 1'b1;
        end
      end
      default: w_next = S_IDLE;
    endcase
    // Reset releases the pipeline at once, even mid-access.
    if (rst) freeze = 1'b0;
    w_pass = ((r_state == S_IDLE) && !w_memop) || w_done;
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // Busy-cycle counter, cleared on issue
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (w_issue) begin
      r_cnt <= '0;
    end else if ((r_state == S_BUSY) && (w_next == S_BUSY)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // Memory request interface, held stable while busy
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else if (w_issue) begin
      mem_req   <= 1'b1;
      mem_we    <= MEM_W_EN_IN;
      mem_addr  <= w_addr;
      mem_wdata <= STValIn;
    end else if (w_done || w_abort) begin
      mem_req   <= 1'b0;
    end
  end

  // MEM->WB bundle: pass on completion, bubble on issue/abort
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      WB_EN    <= 1'b0;
      MEM_R_EN <= 1'b0;
      PC       <= '0;
      ALURes   <= '0;
      MemData  <= '0;
      dest     <= '0;
    end else if (w_pass) begin
      WB_EN    <= WB_EN_IN;
      MEM_R_EN <= MEM_R_EN_IN;
      PC       <= PCIn;
      ALURes   <= ALUResIn;
      dest     <= destIn;
      if (w_done && !mem_we) MemData <= mem_rdata;
    end else if (w_issue || w_abort) begin
      WB_EN    <= 1'b0;
      MEM_R_EN <= 1'b0;
    end
  end

  // Sticky timeout flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst)          mem_err <= 1'b0;
    else if (w_abort) mem_err <= 1'b1;
  end

endmodule
